cmd_stream_issuer: RTL
======================

Name: cmd_stream_issuer

Overview:
Initiator side of the 64-bit command valid/ready interface consumed by the command processor. The host loads commands into an internal FIFO. After a start pulse the block streams them to the processor, honouring backpressure. Issuing stops after the first HALT (opcode 0x00) is accepted; the block then waits for both cores to go idle and reports done.

Parameters:
DEPTH, 16, FIFO depth in 64-bit commands; power of 2, minimum 2.
CNT_W, 16, width of issued_count.

Ports:
clk  in  1  clock
rst  in  1  reset
host_wr_valid  in  1  host offers a command
host_wr_data  in  64  command word: [63:56] opcode, [48] core select
host_wr_ready  out  1  FIFO can accept the offered word
start  in  1  single-cycle pulse that begins issuing
cmd_valid  out  1  command presented to the processor
cmd_data  out  64  command word, equal to the FIFO head
cmd_ready  in  1  processor accepts (may depend combinationally on cmd_data)
core0_ready  in  1  core0 idle
core1_ready  in  1  core1 idle
busy  out  1  state is ISSUE or DRAIN
done  out  1  sequence complete; level signal
issued_count  out  CNT_W  commands accepted since the last start
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset rst: synchronous, active-high. Clock clk.
- Reset value of every output and state register is 0: FIFO empty (flushed), state IDLE, host_wr_ready=0 during reset, cmd_valid=0, cmd_data=0 (don't-care while invalid), busy=0, done=0, issued_count=0, fifo_level=0.
- Reset mid-operation aborts immediately. No further command is presented after the reset cycle.
- FIFO:
  - host_wr_ready = !full && !rst. A push occurs when host_wr_valid && host_wr_ready.
  - A pop occurs when cmd_valid && cmd_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - When full, a push is rejected even if a pop happens in the same cycle, because ready is based on the registered full flag.
  - Pointers wrap modulo DEPTH.
  - A word pushed into an empty FIFO is visible on cmd_data the next cycle.
- cmd_valid = (state==ISSUE) && !empty. It never depends on cmd_ready, so there is no combinational loop.
- cmd_data is driven from the FIFO head. Once cmd_valid rises, cmd_valid and cmd_data hold stable until the handshake completes.
- FSM:
  - IDLE: start -> ISSUE; issued_count cleared, done cleared.
  - ISSUE: each accepted transfer increments issued_count, saturating at all-ones.
    - If the accepted word has opcode [63:56]==0x00, go to DRAIN.
    - If the FIFO is empty, cmd_valid stays low and the block stays in ISSUE waiting for host data. This is not an error.
  - DRAIN: no commands are presented. Words left behind the HALT stay in the FIFO. When core0_ready && core1_ready, go to DONE.
    - This check applies at the earliest one cycle after HALT acceptance, which allows for the processor's start-pulse latency.
  - DONE: done=1 (held). start -> ISSUE, clearing done and issued_count, and resuming from the current FIFO head.
- start is ignored in ISSUE and DRAIN.
- Host pushes are permitted in every state.
- busy=1 in ISSUE and DRAIN.

Decomposition:
- Shared package cmd_pkg: CMD_HALT=8'h00; OPC_MSB=63, OPC_LSB=56; CORE_SEL_BIT=48; issuer state enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module cmd_fifo: parameterised synchronous first-word-fall-through FIFO with full, empty and level outputs. It is reused by other host-side blocks.

Test Plan:
- Reset, then push 3 words (core0 op 0x01, core1 op 0x02, HALT 0x00) with cmd_ready=1 and cores ready, then pulse start -> three cmd_valid beats in consecutive cycles in push order; issued_count=3; done=1 within 2 cycles after the HALT beat.
- Hold cmd_ready=0 for 5 cycles while cmd_valid=1 -> cmd_data is unchanged and no pop occurs; on cmd_ready=1 exactly one transfer occurs and issued_count increments by 1.
- Push DEPTH words -> host_wr_ready=0 and fifo_level=DEPTH. Push attempted while a pop occurs -> word rejected and level becomes DEPTH-1.
- HALT accepted with core1_ready=0 for 10 cycles -> state stays DRAIN, busy=1, done=0; done rises 1 cycle after core1_ready=1.
- Empty FIFO in ISSUE -> cmd_valid=0; a later push of a core0 word -> cmd_valid=1 the next cycle.
- Assert rst mid-stream with 4 words queued -> cmd_valid=0, fifo_level=0, issued_count=0, done=0 the cycle after; a start without pushes produces no cmd_valid.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared command-word layout and issuer FSM encodings for the host-side command blocks.
// Pure declarations: no logic, no state.
package cmd_pkg;

  localparam logic [7:0] CMD_HALT     = 8'h00;
  localparam int         OPC_MSB      = 63;
  localparam int         OPC_LSB      = 56;
  localparam int         CORE_SEL_BIT = 48;

  typedef logic [1:0] issuer_state_t;

  localparam issuer_state_t IDLE  = 2'd0;
  localparam issuer_state_t ISSUE = 2'd1;
  localparam issuer_state_t DRAIN = 2'd2;
  localparam issuer_state_t DONE  = 2'd3;

  function automatic logic is_halt(input logic [63:0] word);
    return word[OPC_MSB:OPC_LSB] == CMD_HALT;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO: a pushed word shows on head the cycle after the push.
// Pushes into a full FIFO and pops from an empty one are ignored; full is derived from registered count.
module cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head reads zero while empty so the output is defined straight out of reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cmd_stream_issuer.sv
// Streams host-loaded commands to the command processor after start, stopping after the first HALT.
// cmd_valid is a function of registered state only; words wait in the FIFO under cmd_ready backpressure.
module cmd_stream_issuer
  import cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_wr_valid,
  input  logic [63:0]            host_wr_data,
  output logic                   host_wr_ready,
  input  logic                   start,
  output logic                   cmd_valid,
  output logic [63:0]            cmd_data,
  input  logic                   cmd_ready,
  input  logic                   core0_ready,
  input  logic                   core1_ready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       issued_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  issuer_state_t state;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign host_wr_ready = !full && !rst;
  assign push          = host_wr_valid && host_wr_ready;
  assign cmd_valid     = (state == ISSUE) && !empty;
  assign pop           = cmd_valid && cmd_ready;
  assign busy          = (state == ISSUE) || (state == DRAIN);
  assign done          = state == DONE;

  cmd_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (host_wr_data),
    .pop       (pop),
    .head      (cmd_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= ISSUE;
            issued_count <= '0;
          end
        end
        ISSUE: begin
          if (pop) begin
            if (issued_count != '1) issued_count <= issued_count + CNT_W'(1);
            if (is_halt(cmd_data)) state <= DRAIN;
          end
        end
        // Entered the cycle after HALT acceptance, so the idle check is
        // naturally one cycle late, covering the processor's start latency.
        DRAIN: begin
          if (core0_ready && core1_ready) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
